// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Scheduler state encodings and floor-index width helper,
//                shared by the scheduler, the controller and the door stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SERVE_UP   = 2'd1;
  localparam logic [1:0] ST_SERVE_DOWN = 2'd2;

  // Width of a floor index; never narrower than one bit.
  function automatic int floor_width(input int floors);
    return (floors <= 2) ? 1 : $clog2(floors);
  endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_floor_pick.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_floor_pick
//  Description : Combinational search of the pending bitmap relative to the
//                car position: any request above / below / at the car, the
//                nearest request above and the nearest request below.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_floor_pick #(
  parameter int FLOORS  = 5,
  parameter int FLOOR_W = 3
) (
  input  logic [FLOORS-1:0]  pending_i,
  input  logic [FLOOR_W-1:0] cur_floor_i,
  output logic               above_o,
  output logic               below_o,
  output logic               here_o,
  output logic [FLOOR_W-1:0] near_up_o,
  output logic [FLOOR_W-1:0] near_dn_o
);

  // Nearest-below: ascending scan, the last hit is the highest index below the car.
  // An out-of-range car position never matches 'here' and sees everything as below.
  always_comb begin
    below_o   = 1'b0;
    here_o    = 1'b0;
    near_dn_o = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_i[i] && (FLOOR_W'(i) < cur_floor_i)) begin
        below_o   = 1'b1;
        near_dn_o = FLOOR_W'(i);
      end
      if (cur_floor_i == FLOOR_W'(i)) begin
        here_o = pending_i[i];
      end
    end
  end

  // Nearest-above: descending scan, the last hit is the lowest index above the car.
  always_comb begin
    above_o   = 1'b0;
    near_up_o = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending_i[i] && (FLOOR_W'(i) > cur_floor_i)) begin
        above_o   = 1'b1;
        near_up_o = FLOOR_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_request_scheduler
//  Description : Latches floor requests into a pending bitmap, clears them on
//                arrival and issues one SCAN-ordered target floor at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS  = 5,
  parameter int FLOOR_W = floor_width(FLOORS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLOORS-1:0]  btn_i,
  input  logic [FLOOR_W-1:0] cur_floor_i,
  input  logic               arrived_i,
  output logic [FLOOR_W-1:0] target_floor_o,
  output logic               target_valid_o,
  output logic [FLOORS-1:0]  pending_o,
  output logic               moving_up_o,
  output logic               moving_down_o
);

  logic [FLOORS-1:0]  pending_q, pending_d;
  logic [FLOORS-1:0]  w_clr;
  logic [1:0]         state_q, state_d;
  logic [FLOOR_W-1:0] target_q, target_d;
  logic               valid_q, valid_d;
  logic               moving_up_q, moving_down_q;

  logic               w_above, w_below, w_here;
  logic [FLOOR_W-1:0] w_near_up, w_near_dn;

  elevator_floor_pick #(
    .FLOORS  (FLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_floor_pick (
    .pending_i   (pending_q),
    .cur_floor_i (cur_floor_i),
    .above_o     (w_above),
    .below_o     (w_below),
    .here_o      (w_here),
    .near_up_o   (w_near_up),
    .near_dn_o   (w_near_dn)
  );

  // Arrival clear mask: one-hot on the car floor; an out-of-range floor matches nothing.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < FLOORS; i++) begin
      w_clr[i] = arrived_i && (cur_floor_i == FLOOR_W'(i));
    end
    pending_d = (pending_q | btn_i) & ~w_clr;
  end

  // SCAN scheduler: keep the current direction while work remains ahead, then reverse.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (w_above) begin
          state_d = ST_SERVE_UP;   target_d = w_near_up;   valid_d = 1'b1;
        end else if (w_below) begin
          state_d = ST_SERVE_DOWN; target_d = w_near_dn;   valid_d = 1'b1;
        end else if (w_here) begin
          state_d = ST_IDLE;       target_d = cur_floor_i; valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_SERVE_UP: begin
        if (w_above) begin
          target_d = w_near_up;   valid_d = 1'b1;
        end else if (w_here) begin
          target_d = cur_floor_i; valid_d = 1'b1;
        end else if (w_below) begin
          state_d = ST_SERVE_DOWN; target_d = w_near_dn; valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;       valid_d = 1'b0;
        end
      end
      ST_SERVE_DOWN: begin
        if (w_below) begin
          target_d = w_near_dn;   valid_d = 1'b1;
        end else if (w_here) begin
          target_d = cur_floor_i; valid_d = 1'b1;
        end else if (w_above) begin
          state_d = ST_SERVE_UP;   target_d = w_near_up; valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;       valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, request bitmap and registered outputs; reset drops every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      state_q       <= ST_IDLE;
      target_q      <= '0;
      valid_q       <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      state_q       <= state_d;
      target_q      <= target_d;
      valid_q       <= valid_d;
      moving_up_q   <= (state_d == ST_SERVE_UP);
      moving_down_q <= (state_d == ST_SERVE_DOWN);
    end
  end

  assign pending_o      = pending_q;
  assign target_floor_o = target_q;
  assign target_valid_o = valid_q;
  assign moving_up_o    = moving_up_q;
  assign moving_down_o  = moving_down_q;

endmodule
`default_nettype wire
